// File: rtl/lcm_inverse_pkg.sv
// Shared types and width helpers for the LCM-inverse datapath.
// Widths derive from the operand width: gcd/lcm are 2x, the gcd*lcm product is 4x.
`timescale 1ns/1ps
package lcm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } inv_state_t;

    localparam int WIDE_FACTOR = 2;
    localparam int PROD_FACTOR = 4;

    function automatic int wide_width(input int data_width);
        return WIDE_FACTOR * data_width;
    endfunction

    function automatic int prod_width(input int data_width);
        return PROD_FACTOR * data_width;
    endfunction

    function automatic int cnt_width(input int data_width);
        return $clog2(PROD_FACTOR * data_width);
    endfunction

endpackage

// File: rtl/lcm_inverse_if.sv
// Request/result bundle between the GCD/LCM engine side and lcm_inverse.
`timescale 1ns/1ps
interface lcm_inverse_if #(
    parameter int DATA_WIDTH = 8
);
    import lcm_pkg::*;

    localparam int WIDE_W = wide_width(DATA_WIDTH);

    logic                  en;
    logic [DATA_WIDTH-1:0] a;
    logic [WIDE_W-1:0]     gcd;
    logic [WIDE_W-1:0]     lcm;
    logic                  valid;
    logic [DATA_WIDTH-1:0] b;
    logic                  err;
    logic                  busy;

    modport master (
        output en, a, gcd, lcm,
        input  valid, b, err, busy
    );

    modport slave (
        input  en, a, gcd, lcm,
        output valid, b, err, busy
    );

endinterface

// File: rtl/lcm_inverse_serial_div.sv
// Serial restoring divider, one quotient bit per cycle, dividend MSB first.
// quotient/remainder present the post-step values, so they are final in the done cycle.
`timescale 1ns/1ps
module serial_div #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W:0]    remainder
);
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    logic [DIVIDEND_W-1:0] p_q;
    logic [DIVIDEND_W-1:0] q_q;
    logic [DIVISOR_W-1:0]  r_q;
    logic [CNT_W-1:0]      cnt;
    logic                  running;

    logic [DIVISOR_W:0]    r_shift;
    logic [DIVISOR_W:0]    r_next;
    logic [DIVIDEND_W-1:0] q_next;
    logic                  ge;

    // Quotient bits are written MSB first by index rather than shifted, equivalent since Q starts at 0.
    always_comb begin
        r_shift = {r_q, p_q[DIVIDEND_W-1]};
        ge      = (r_shift >= {1'b0, divisor});
        r_next  = ge ? (r_shift - {1'b0, divisor}) : r_shift;
        q_next  = q_q;
        q_next[LAST - cnt] = ge;
    end

    assign done      = running && (cnt == LAST);
    assign quotient  = q_next;
    assign remainder = r_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            p_q     <= dividend;
            q_q     <= '0;
            r_q     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            p_q     <= {p_q[DIVIDEND_W-2:0], 1'b0};
            q_q     <= q_next;
            r_q     <= r_next[DIVISOR_W-1:0];
            cnt     <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lcm_inverse.sv
// Recovers b = (gcd * lcm) / a and flags triples whose product is not an exact
// DATA_WIDTH-bit multiple of a. Zero a or gcd short-circuits straight to an error result.
`timescale 1ns/1ps
module lcm_inverse
    import lcm_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    lcm_inverse_if.slave  bus
);
    localparam int WIDE_W = wide_width(DATA_WIDTH);
    localparam int PROD_W = prod_width(DATA_WIDTH);

    inv_state_t state;
    inv_state_t state_next;

    logic                  en_r1;
    logic                  en_r2;
    logic                  start;
    logic                  early_err;
    logic [DATA_WIDTH-1:0] a_q;
    logic [WIDE_W-1:0]     gcd_q;
    logic [WIDE_W-1:0]     lcm_q;
    logic [PROD_W-1:0]     product;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  err_q;

    logic                  div_start;
    logic                  div_done;
    logic [PROD_W-1:0]     quo;
    logic [DATA_WIDTH:0]   rem;
    logic                  result_err;

    assign start      = en_r1 & ~en_r2;
    assign early_err  = (bus.a == '0) || (bus.gcd == '0);
    assign product    = {{WIDE_W{1'b0}}, gcd_q} * {{WIDE_W{1'b0}}, lcm_q};
    assign div_start  = (state == LOAD);
    assign result_err = (rem != '0) || (quo[PROD_W-1:DATA_WIDTH] != '0);

    assign bus.valid = (state == DONE);
    assign bus.busy  = (state != IDLE);
    assign bus.b     = b_q;
    assign bus.err   = err_q;

    serial_div #(
        .DIVIDEND_W (PROD_W),
        .DIVISOR_W  (DATA_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (product),
        .divisor   (a_q),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            en_r1 <= 1'b0;
            en_r2 <= 1'b0;
            a_q   <= '0;
            gcd_q <= '0;
            lcm_q <= '0;
            b_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            en_r1 <= bus.en;
            en_r2 <= en_r1;
            if (state == IDLE && start) begin
                a_q   <= bus.a;
                gcd_q <= bus.gcd;
                lcm_q <= bus.lcm;
                if (early_err) begin
                    b_q   <= '0;
                    err_q <= 1'b1;
                end
            end
            // b/err only change when a result is produced, so they hold between operations.
            if (state == DIV && div_done) begin
                err_q <= result_err;
                b_q   <= result_err ? '0 : quo[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = early_err ? DONE : LOAD;
                end
            end
            LOAD: state_next = DIV;
            DIV: begin
                if (div_done) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcm_inverse.sv
// Directed bench for lcm_inverse: table of operand triples with hand-computed results,
// plus retrigger, held-enable and mid-division reset sequences.
`timescale 1ns/1ps
module tb_lcm_inverse;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    lcm_inverse_if #(.DATA_WIDTH(8)) bus ();

    lcm_inverse #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] gcd;
        logic [15:0] lcm;
        logic [7:0]  exp_b;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic countValids(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) cnt++;
        end
    endtask

    // Raises en at a negedge, counts edges from the first edge that samples it until valid.
    task automatic applyStimulus(input logic [7:0] a, input logic [15:0] gcd, input logic [15:0] lcm,
                                 output int lat, output logic [7:0] b_out, output logic err_out,
                                 output logic busy_after, output logic valid_after);
        bit got;
        @(negedge clk);
        bus.a   = a;
        bus.gcd = gcd;
        bus.lcm = lcm;
        bus.en  = 1'b1;
        @(posedge clk);
        lat = 0;
        got = 0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.valid === 1'b1) got = 1;
        end
        b_out   = bus.b;
        err_out = bus.err;
        bus.en  = 1'b0;
        @(posedge clk);
        #1;
        busy_after  = bus.busy;
        valid_after = bus.valid;
    endtask

    initial begin
        int         lat;
        int         c1, c2, c3, c4;
        logic [7:0] b_out;
        logic       err_out, busy_after, valid_after;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{a: 8'd12,  gcd: 16'd6,   lcm: 16'd36,    exp_b: 8'd18,  exp_err: 1'b0, exp_lat: 34};
        vecs[1] = '{a: 8'd0,   gcd: 16'd6,   lcm: 16'd36,    exp_b: 8'd0,   exp_err: 1'b1, exp_lat: 1};
        vecs[2] = '{a: 8'd12,  gcd: 16'd0,   lcm: 16'd36,    exp_b: 8'd0,   exp_err: 1'b1, exp_lat: 1};
        vecs[3] = '{a: 8'd5,   gcd: 16'd1,   lcm: 16'd7,     exp_b: 8'd0,   exp_err: 1'b1, exp_lat: 34};
        vecs[4] = '{a: 8'd1,   gcd: 16'd255, lcm: 16'd255,   exp_b: 8'd0,   exp_err: 1'b1, exp_lat: 34};
        vecs[5] = '{a: 8'd255, gcd: 16'd1,   lcm: 16'd65025, exp_b: 8'd255, exp_err: 1'b0, exp_lat: 34};
        vecs[6] = '{a: 8'd21,  gcd: 16'd7,   lcm: 16'd84,    exp_b: 8'd28,  exp_err: 1'b0, exp_lat: 34};
        vecs[7] = '{a: 8'd200, gcd: 16'd1,   lcm: 16'd200,   exp_b: 8'd1,   exp_err: 1'b0, exp_lat: 34};

        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.a   = '0;
        bus.gcd = '0;
        bus.lcm = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", bus.valid, 0);
        checkOutput("reset_b",     bus.b,     0);
        checkOutput("reset_err",   bus.err,   0);
        checkOutput("reset_busy",  bus.busy,  0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].gcd, vecs[i].lcm, lat, b_out, err_out, busy_after, valid_after);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d_b", i), b_out, vecs[i].exp_b);
            checkOutput($sformatf("vec%0d_err", i), err_out, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_busy_after", i), busy_after, 0);
            checkOutput($sformatf("vec%0d_valid_after", i), valid_after, 0);
        end

        // Drop and re-raise en mid-division while also changing the operands.
        @(negedge clk);
        bus.a   = 8'd12;
        bus.gcd = 16'd6;
        bus.lcm = 16'd36;
        bus.en  = 1'b1;
        countValids(12, c1);
        bus.en  = 1'b0;
        bus.a   = 8'd5;
        bus.gcd = 16'd1;
        bus.lcm = 16'd7;
        countValids(3, c2);
        bus.en  = 1'b1;
        countValids(60, c3);
        bus.en  = 1'b0;
        countValids(3, c4);
        checkOutput("retrigger_valid_count", c1 + c2 + c3 + c4, 1);
        checkOutput("retrigger_b",   bus.b,   18);
        checkOutput("retrigger_err", bus.err, 0);

        @(negedge clk);
        bus.a   = 8'd21;
        bus.gcd = 16'd7;
        bus.lcm = 16'd84;
        bus.en  = 1'b1;
        countValids(100, c1);
        bus.en  = 1'b0;
        countValids(3, c2);
        checkOutput("hold_en_valid_count", c1 + c2, 1);
        checkOutput("hold_en_b", bus.b, 28);

        // Reset lands between edges around DIV step 10; outputs must clear without a clock.
        @(negedge clk);
        bus.a   = 8'd12;
        bus.gcd = 16'd6;
        bus.lcm = 16'd36;
        bus.en  = 1'b1;
        countValids(12, c1);
        checkOutput("midreset_busy_before", bus.busy, 1);
        #2;
        rst    = 1'b1;
        bus.en = 1'b0;
        #1;
        checkOutput("midreset_valid", bus.valid, 0);
        checkOutput("midreset_b",     bus.b,     0);
        checkOutput("midreset_err",   bus.err,   0);
        checkOutput("midreset_busy",  bus.busy,  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        countValids(40, c2);
        checkOutput("midreset_no_valid", c1 + c2, 0);

        applyStimulus(8'd12, 16'd6, 16'd36, lat, b_out, err_out, busy_after, valid_after);
        checkOutput("post_reset_latency", lat, 34);
        checkOutput("post_reset_b",       b_out, 18);
        checkOutput("post_reset_err",     err_out, 0);
        checkOutput("post_reset_busy",    busy_after, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
